// File: rtl/alu_issue_pkg.sv
// Shared opcodes, sequencer state encoding and per-opcode EXEC latency for the ALU issue sequencer.
package alu_issue_pkg;

   localparam logic [5:0] OP_ADD  = 6'd0;
   localparam logic [5:0] OP_SUB  = 6'd1;
   localparam logic [5:0] OP_NEG  = 6'd2;
   localparam logic [5:0] OP_MUL  = 6'd3;
   localparam logic [5:0] OP_DIV  = 6'd4;
   localparam logic [5:0] OP_OR   = 6'd5;
   localparam logic [5:0] OP_XOR  = 6'd6;
   localparam logic [5:0] OP_NAND = 6'd7;
   localparam logic [5:0] OP_NOR  = 6'd8;
   localparam logic [5:0] OP_XNOR = 6'd9;
   localparam logic [5:0] OP_NOT  = 6'd10;
   localparam logic [5:0] OP_SHL  = 6'd11;
   localparam logic [5:0] OP_SHR  = 6'd12;
   localparam logic [5:0] OP_MAX  = 6'd12;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StLoad,
      StExec,
      StDone
   } state_e;

   function automatic int unsigned op_latency(input logic [5:0]  opcode,
                                              input int unsigned mul_lat,
                                              input int unsigned div_lat);
      int unsigned lat;
      case (opcode)
         OP_MUL:  lat = mul_lat;
         OP_DIV:  lat = div_lat;
         default: lat = 1;
      endcase
      return lat;
   endfunction

endpackage

// File: rtl/alu_issue_lat_cnt.sv
// EXEC latency counter: loaded with (latency - 1), counts down while enabled, holds at zero.
module alu_issue_lat_cnt #(
   parameter int unsigned CW = 5
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          en_i,
   output logic          zero_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_issue_seq.sv
// Single-issue sequencer driving the shared ALU: read operands, wait op latency, hand off result.
// Optional perf counters (perf_ops_o, perf_stall_o) are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_seq
   import alu_issue_pkg::*;
#(
   parameter int unsigned DW      = 16,
   parameter int unsigned AW      = 6,
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            instr_valid_i,
   output logic            instr_ready_o,
   input  logic [31:0]     instr_i,
   output logic            rf_rd_en_o,
   output logic [AW-1:0]   rf_addr_a_o,
   output logic [AW-1:0]   rf_addr_b_o,
   input  logic [DW-1:0]   rf_data_a_i,
   input  logic [DW-1:0]   rf_data_b_i,
   output logic [5:0]      alu_sel_o,
   output logic [DW-1:0]   alu_a_o,
   output logic [DW-1:0]   alu_b_o,
   input  logic [2*DW-1:0] alu_res_i,
   output logic            res_valid_o,
   input  logic            res_ready_i,
   output logic [2*DW-1:0] res_data_o,
   output logic [AW-1:0]   res_dst_o,
   output logic            res_err_o,
   output logic            busy_o
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]     perf_ops_o,
   output logic [31:0]     perf_stall_o
`endif
);

   localparam int unsigned CW = $clog2(DIV_LAT + 1);

   state_e            state_q;
   logic [5:0]        opcode_q;
   logic [AW-1:0]     dst_q, src_a_q, src_b_q;
   logic              rf_rd_en_q;
   logic [5:0]        alu_sel_q;
   logic [DW-1:0]     alu_a_q, alu_b_q;
   logic              res_valid_q;
   logic [2*DW-1:0]   res_data_q;
   logic [AW-1:0]     res_dst_q;
   logic              res_err_q;

   logic [5:0]        in_opcode;
   logic              cnt_zero;
   logic [31:0]       lat_full;
   logic [CW-1:0]     lat_load;
   logic [2*DW-1:0]   cap_data;
   logic              cap_err;
   logic              unused_instr_bits;

   assign in_opcode         = instr_i[31:26];
   assign unused_instr_bits = ^instr_i[7:0];

   // Counter holds latency-1 so a 1-cycle op spends exactly one cycle in EXEC.
   assign lat_full = op_latency(opcode_q, MUL_LAT, DIV_LAT) - 32'd1;
   assign lat_load = lat_full[CW-1:0];

   alu_issue_lat_cnt #(
      .CW (CW)
   ) u_lat_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (state_q == StLoad),
      .load_val_i (lat_load),
      .en_i       (state_q == StExec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      cap_data = {{DW{1'b0}}, alu_res_i[DW-1:0]};
      cap_err  = 1'b0;
      if ((opcode_q == OP_DIV) && (alu_a_q == '0)) begin
         cap_data = {{DW{1'b0}}, {DW{1'b1}}};
         cap_err  = 1'b1;
      end else if (opcode_q == OP_MUL) begin
         cap_data = alu_res_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         opcode_q    <= '0;
         dst_q       <= '0;
         src_a_q     <= '0;
         src_b_q     <= '0;
         rf_rd_en_q  <= 1'b0;
         alu_sel_q   <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_dst_q   <= '0;
         res_err_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (instr_valid_i) begin
                  opcode_q <= in_opcode;
                  dst_q    <= instr_i[25:20];
                  src_a_q  <= instr_i[19:14];
                  src_b_q  <= instr_i[13:8];
                  if (in_opcode > OP_MAX) begin
                     res_data_q  <= '0;
                     res_err_q   <= 1'b1;
                     res_dst_q   <= instr_i[25:20];
                     res_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end else begin
                     alu_sel_q  <= in_opcode;
                     rf_rd_en_q <= 1'b1;
                     state_q    <= StRead;
                  end
               end
            end
            StRead: begin
               rf_rd_en_q <= 1'b0;
               state_q    <= StLoad;
            end
            StLoad: begin
               alu_a_q <= rf_data_a_i;
               alu_b_q <= rf_data_b_i;
               state_q <= StExec;
            end
            StExec: begin
               if (cnt_zero) begin
                  res_data_q  <= cap_data;
                  res_err_q   <= cap_err;
                  res_dst_q   <= dst_q;
                  res_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign instr_ready_o = (state_q == StIdle);
   assign busy_o        = (state_q != StIdle);
   assign rf_rd_en_o    = rf_rd_en_q;
   assign rf_addr_a_o   = src_a_q;
   assign rf_addr_b_o   = src_b_q;
   assign alu_sel_o     = alu_sel_q;
   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign res_valid_o   = res_valid_q;
   assign res_data_o    = res_data_q;
   assign res_dst_o     = res_dst_q;
   assign res_err_o     = res_err_q;

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_ops_q, perf_stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_ops_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (res_valid_q && res_ready_i) begin
            perf_ops_q <= perf_ops_q + 32'd1;
         end
         if ((state_q == StDone) && !res_ready_i) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_ops_o   = perf_ops_q;
   assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a register-file model and a behavioural ALU.
module tb_alu_issue_seq;
   import alu_issue_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr;
   logic            rf_rd_en;
   logic [AW-1:0]   rf_addr_a, rf_addr_b;
   logic [DW-1:0]   rf_data_a, rf_data_b;
   logic [5:0]      alu_sel;
   logic [DW-1:0]   alu_a, alu_b;
   logic [2*DW-1:0] alu_res;
   logic            res_valid;
   logic            res_ready;
   logic [2*DW-1:0] res_data;
   logic [AW-1:0]   res_dst;
   logic            res_err;
   logic            busy;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0]     perf_ops, perf_stall;
`endif

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] rf_mem [64];

   always #5 clk = ~clk;

   alu_issue_seq #(
      .DW      (DW),
      .AW      (AW),
      .MUL_LAT (4),
      .DIV_LAT (16)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .instr_valid_i (instr_valid),
      .instr_ready_o (instr_ready),
      .instr_i       (instr),
      .rf_rd_en_o    (rf_rd_en),
      .rf_addr_a_o   (rf_addr_a),
      .rf_addr_b_o   (rf_addr_b),
      .rf_data_a_i   (rf_data_a),
      .rf_data_b_i   (rf_data_b),
      .alu_sel_o     (alu_sel),
      .alu_a_o       (alu_a),
      .alu_b_o       (alu_b),
      .alu_res_i     (alu_res),
      .res_valid_o   (res_valid),
      .res_ready_i   (res_ready),
      .res_data_o    (res_data),
      .res_dst_o     (res_dst),
      .res_err_o     (res_err),
      .busy_o        (busy)
`ifdef ALU_ISSUE_PERF_EN
      ,
      .perf_ops_o    (perf_ops),
      .perf_stall_o  (perf_stall)
`endif
   );

   always @(posedge clk) begin
      if (rf_rd_en) begin
         rf_data_a <= rf_mem[rf_addr_a];
         rf_data_b <= rf_mem[rf_addr_b];
      end
   end

   // Junk in the upper half for non-MUL ops so masking is observable.
   always_comb begin
      alu_res = 32'h0;
      case (alu_sel)
         OP_ADD:  alu_res = {16'hA5A5, alu_a + alu_b};
         OP_SUB:  alu_res = {16'hA5A5, alu_b + ~alu_a};
         OP_NEG:  alu_res = {16'hA5A5, ~alu_a + 16'd1};
         OP_MUL:  alu_res = {16'h0, alu_a} * {16'h0, alu_b};
         OP_DIV:  alu_res = (alu_a == 16'h0) ? 32'h0000_1234 : {16'hA5A5, alu_b / alu_a};
         OP_OR:   alu_res = {16'hA5A5, alu_a | alu_b};
         OP_XOR:  alu_res = {16'hA5A5, alu_a ^ alu_b};
         OP_NOT:  alu_res = {16'hA5A5, ~alu_a};
         OP_SHL:  alu_res = {16'hA5A5, alu_b << alu_a[3:0]};
         default: alu_res = 32'hA5A5_0000;
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [5:0] op, input logic [5:0] dst, input logic [5:0] s1,
                        input logic [5:0] s2);
      @(negedge clk);
      instr       = {op, dst, s1, s2, 8'h00};
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] dst,
                         input logic [5:0] s1, input logic [5:0] s2, input logic [31:0] exp_data,
                         input logic exp_err, input int exp_lat);
      int  n = 0;
      int  pulses = 0;
      bit  rdy_seen = 1'b0;
      bit  got = 1'b0;
      issue(op, dst, s1, s2);
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         if (rf_rd_en) pulses++;
         if (instr_ready) rdy_seen = 1'b1;
         if (res_valid) got = 1'b1;
      end
      check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat));
      check_eq({tag, "_data"}, 64'(res_data), 64'(exp_data));
      check_eq({tag, "_dst"}, 64'(res_dst), 64'(dst));
      check_eq({tag, "_err"}, 64'(res_err), 64'(exp_err));
      check_eq({tag, "_rdpulse"}, 64'(pulses), (op > OP_MAX) ? 64'd0 : 64'd1);
      check_eq({tag, "_rdy_low"}, 64'(rdy_seen), 64'd0);
      @(negedge clk);
      check_eq({tag, "_back_idle"}, 64'({instr_ready, res_valid, busy}), 64'b100);
   endtask

   initial begin
      int n;
      foreach (rf_mem[i]) rf_mem[i] = 16'h0;
      rf_mem[3]  = 16'h0005;
      rf_mem[4]  = 16'h0007;
      rf_mem[10] = 16'h0100;
      rf_mem[11] = 16'h0100;
      rf_mem[12] = 16'h0064;
      rf_mem[13] = 16'h0007;
      rst_n = 1'b0;
      instr_valid = 1'b0;
      instr = 32'h0;
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_ctrl", 64'({instr_ready, busy, rf_rd_en, res_valid, res_err}), 64'b10000);
      check_eq("rst_alu", 64'({alu_sel, alu_a, alu_b}), 64'h0);
      check_eq("rst_res", 64'({res_data, res_dst}), 64'h0);
      rst_n = 1'b1;

      run_op("add",   OP_ADD, 6'd9,  6'd3,  6'd4,  32'h0000_000C, 1'b0, 4);
      run_op("mul",   OP_MUL, 6'd1,  6'd10, 6'd11, 32'h0001_0000, 1'b0, 7);
      run_op("div0",  OP_DIV, 6'd2,  6'd0,  6'd4,  32'h0000_FFFF, 1'b1, 19);
      run_op("ill3f", 6'h3F,  6'd5,  6'd3,  6'd4,  32'h0,         1'b1, 1);
      run_op("ill13", 6'd13,  6'd6,  6'd3,  6'd4,  32'h0,         1'b1, 1);
      run_op("sub",   OP_SUB, 6'd7,  6'd3,  6'd4,  32'h0000_0001, 1'b0, 4);
      run_op("div",   OP_DIV, 6'd8,  6'd13, 6'd12, 32'h0000_000E, 1'b0, 19);
      run_op("not",   OP_NOT, 6'd3,  6'd3,  6'd3,  32'h0000_FFFA, 1'b0, 4);
      run_op("neg",   OP_NEG, 6'd4,  6'd3,  6'd4,  32'h0000_FFFB, 1'b0, 4);
      run_op("xor",   OP_XOR, 6'd11, 6'd3,  6'd4,  32'h0000_0002, 1'b0, 4);
      run_op("shl",   OP_SHL, 6'd12, 6'd3,  6'd4,  32'h0000_00E0, 1'b0, 4);

      // Back-pressure: hold res_ready low for 10 DONE cycles.
      res_ready = 1'b0;
      issue(OP_ADD, 6'd2, 6'd3, 6'd4);
      n = 0;
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("stall_lat", 64'(n), 64'd4);
      repeat (10) @(posedge clk);
      #1;
      check_eq("stall_hold", 64'({res_valid, instr_ready, busy, res_err}), 64'b1010);
      check_eq("stall_data", 64'({res_data, res_dst}), {26'h0, 32'h0000_000C, 6'd2});
`ifdef ALU_ISSUE_PERF_EN
      check_eq("perf_stall", 64'(perf_stall), 64'd10);
      check_eq("perf_ops_pre", 64'(perf_ops), 64'd11);
`endif
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("stall_release", 64'({instr_ready, res_valid}), 64'b10);
`ifdef ALU_ISSUE_PERF_EN
      check_eq("perf_ops", 64'(perf_ops), 64'd12);
`endif

      // Asynchronous reset in the middle of a DIV's EXEC phase.
      issue(OP_DIV, 6'd9, 6'd13, 6'd12);
      repeat (6) @(negedge clk);
      check_eq("abort_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort_ctrl", 64'({instr_ready, busy, rf_rd_en, res_valid, res_err}), 64'b10000);
      check_eq("abort_alu", 64'({alu_sel, alu_a, alu_b}), 64'h0);
      check_eq("abort_res", 64'({res_data, res_dst}), 64'h0);
`ifdef ALU_ISSUE_PERF_EN
      check_eq("abort_perf", 64'({perf_ops, perf_stall}), 64'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst_add", OP_ADD, 6'd9, 6'd3, 6'd4, 32'h0000_000C, 1'b0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
